// File: rtl/jpegls_bit_packer.sv
// jpegls_bit_packer
//   Packs right-aligned variable-length codewords into the JPEG-LS byte
//   stream, MSB first. After every emitted 0xFF byte the next byte carries
//   a stuffed 0 bit in its MSB and only 7 payload bits. A flush drains all
//   buffered bits and zero-pads the final partial byte. Then it pulses
//   flush_done for one cycle.
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous, active-high
//   encoded_pixel  : codeword, right-aligned (low encoded_length bits used)
//   encoded_length : number of valid codeword bits, 0..encodedpixel_width
//   in_valid       : codeword present
//   in_ready       : packer can take a codeword (registered state only)
//   flush          : end of image, sampled while in_ready is high
//   out_byte       : stream byte (registered)
//   out_valid      : out_byte valid (registered)
//   out_ready      : downstream accepts out_byte
//   flush_done     : one-cycle pulse once a flush has fully drained
module jpegls_bit_packer #(
  parameter int encodedpixel_width  = 32,
  parameter int encodedlength_width = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [encodedpixel_width-1:0]  encoded_pixel,
  input  logic [encodedlength_width-1:0] encoded_length,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           flush,
  output logic [7:0]                     out_byte,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           flush_done
);

  localparam int AW = encodedpixel_width + 8;
  localparam int FW = $clog2(AW + 1);

  typedef enum logic [1:0] {ACTIVE, FLUSH, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            stuff_q, stuff_d;
  logic [7:0]      out_byte_q, out_byte_d;
  logic            out_valid_q, out_valid_d;
  logic            flush_done_q, flush_done_d;

  logic [FW-1:0]   need;
  logic [FW-1:0]   len_ext;
  logic [FW-1:0]   shamt;
  logic [AW-1:0]   code_m;
  logic [AW-1:0]   acc_app;
  logic [FW-1:0]   fill_app;
  logic [7:0]      byte_cand;
  logic            accept;
  logic            out_free;
  logic            full_emit;
  logic            pad_emit;

  assign need     = stuff_q ? FW'(7) : FW'(8);
  assign in_ready = (state_q == ACTIVE) && (fill_q < need);
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  assign out_byte   = out_byte_q;
  assign out_valid  = out_valid_q;
  assign flush_done = flush_done_q;

  always_comb begin
    len_ext   = FW'(encoded_length);
    // Bits outside the codeword are masked so the accumulator below fill
    // always stays zero; padding then comes for free.
    code_m    = AW'(encoded_pixel) & ~({AW{1'b1}} << len_ext);
    shamt     = FW'(AW) - fill_q - len_ext;
    acc_app   = acc_q;
    fill_app  = fill_q;
    if (accept) begin
      acc_app  = acc_q | (code_m << shamt);
      fill_app = fill_q + len_ext;
    end

    // Emission looks at the accumulator including this cycle's codeword:
    // appending below the held bits and then shifting out the top byte is
    // equivalent to shifting first and appending below the remainder, and
    // it lets a freshly accepted full byte leave on the same edge.
    byte_cand = stuff_q ? {1'b0, acc_app[AW-1 -: 7]} : acc_app[AW-1 -: 8];
    full_emit = out_free && (fill_app >= need);
    pad_emit  = (state_q == FLUSH) && out_free && (fill_app < need) &&
                ((fill_app != '0) || stuff_q);

    acc_d       = acc_app;
    fill_d      = fill_app;
    stuff_d     = stuff_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q && !out_ready;

    if (full_emit) begin
      acc_d  = acc_app << need;
      fill_d = fill_app - need;
    end else if (pad_emit) begin
      acc_d  = '0;
      fill_d = '0;
    end
    if (full_emit || pad_emit) begin
      out_byte_d  = byte_cand;
      out_valid_d = 1'b1;
      stuff_d     = (byte_cand == 8'hFF);
    end

    state_d = state_q;
    unique case (state_q)
      ACTIVE: if (in_ready && flush) state_d = FLUSH;
      FLUSH:  if ((fill_q == '0) && !stuff_q && out_free) state_d = DONE;
      DONE: begin
        state_d = ACTIVE;
        stuff_d = 1'b0;
      end
      default: state_d = ACTIVE;
    endcase

    flush_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ACTIVE;
      acc_q        <= '0;
      fill_q       <= '0;
      stuff_q      <= 1'b0;
      out_byte_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      stuff_q      <= stuff_d;
      out_byte_q   <= out_byte_d;
      out_valid_q  <= out_valid_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule

// File: tb/tb_jpegls_bit_packer.sv
// Testbench for jpegls_bit_packer: table of single-codeword+flush vectors,
// plus hand-written sequences for latency, stuffing across codewords,
// backpressure and asynchronous reset.
module tb_jpegls_bit_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] encoded_pixel = '0;
  logic [5:0]  encoded_length = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        flush_done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [7:0] got[$];

  jpegls_bit_packer #(
    .encodedpixel_width(32),
    .encodedlength_width(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .encoded_pixel(encoded_pixel),
    .encoded_length(encoded_length),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush(flush),
    .out_byte(out_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge, so at the falling edge
  // everything is stable; a byte seen here is taken at the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) got.push_back(out_byte);
      if (flush_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic send(input logic [31:0] c, input logic [5:0] l, input logic f);
    int n = 0;
    encoded_pixel  = c;
    encoded_length = l;
    flush          = f;
    in_valid       = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) timeout("send_in_ready");
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    int start = done_cnt;
    while (done_cnt == start && n < 200) begin
      tick();
      n++;
    end
    if (done_cnt == start) timeout(nm);
    else chk({nm, "_pulse_end"}, {47'b0, flush_done}, 48'd0);
  endtask

  task automatic chk_bytes(input string nm, input int n, input logic [47:0] exp);
    chk({nm, "_count"}, 48'(got.size()), 48'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got.size())
        chk($sformatf("%s_byte%0d", nm, i), {40'b0, got[i]}, {40'b0, exp[47-8*i -: 8]});
    end
  endtask

  typedef struct packed {
    logic [31:0] code;
    logic [5:0]  len;
    logic [3:0]  n;
    logic [47:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Each vector: one codeword presented together with flush.
    tbl[0] = '{32'h0000_0001, 6'd1,  4'd1, 48'h80_0000_0000_00};
    tbl[1] = '{32'h0000_00A5, 6'd8,  4'd1, 48'hA5_0000_0000_00};
    tbl[2] = '{32'h0000_00FF, 6'd8,  4'd2, 48'hFF_00_0000_0000};
    tbl[3] = '{32'h1234_5678, 6'd32, 4'd4, 48'h12_34_56_78_0000};
    tbl[4] = '{32'h0000_0000, 6'd0,  4'd0, 48'h0};
    tbl[5] = '{32'h0000_0007, 6'd3,  4'd1, 48'hE0_0000_0000_00};
    tbl[6] = '{32'h0000_003F, 6'd6,  4'd1, 48'hFC_0000_0000_00};
    // 32 ones: FF, 7 bits, FF, 7 bits, 2 bits padded.
    tbl[7] = '{32'hFFFF_FFFF, 6'd32, 4'd5, 48'hFF_7F_FF_7F_C0_00};
    // Upper garbage must be masked: 9 ones -> FF then stuffed 0,1,000000.
    tbl[8] = '{32'hFFFF_F1FF, 6'd9,  4'd2, 48'hFF_40_0000_0000};
    tbl[9] = '{32'hABCD_EF01, 6'd0,  4'd0, 48'h0};

    // Reset values
    tick();
    tick();
    chk("rst_out_valid", {47'b0, out_valid}, 48'd0);
    chk("rst_out_byte", {40'b0, out_byte}, 48'd0);
    chk("rst_flush_done", {47'b0, flush_done}, 48'd0);
    chk("rst_in_ready", {47'b0, in_ready}, 48'd1);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", {47'b0, in_ready}, 48'd1);

    // Table vectors
    for (int v = 0; v < 10; v++) begin
      got.delete();
      send(tbl[v].code, tbl[v].len, 1'b1);
      wait_done($sformatf("vec%0d_done", v));
      chk_bytes($sformatf("vec%0d", v), int'(tbl[v].n), tbl[v].exp);
      tick();
    end

    // Latency: byte valid in the cycle after acceptance, in_ready back high.
    got.delete();
    send(32'hA5, 6'd8, 1'b0);
    chk("lat_out_valid", {47'b0, out_valid}, 48'd1);
    chk("lat_out_byte", {40'b0, out_byte}, 48'hA5);
    chk("lat_in_ready", {47'b0, in_ready}, 48'd1);
    tick();
    chk_bytes("lat", 1, 48'hA5_0000_0000_00);

    // Stuffing carries across codewords: 17 ones -> FF, 7F, then 2 bits.
    got.delete();
    send(32'hFFFF, 6'd16, 1'b0);
    send(32'h1, 6'd1, 1'b0);
    send(32'h0, 6'd0, 1'b1);
    wait_done("stuff_seq_done");
    chk_bytes("stuff_seq", 3, 48'hFF_7F_C0_0000_00);

    // Backpressure on a 32-bit codeword.
    got.delete();
    out_ready = 1'b0;
    send(32'h1234_5678, 6'd32, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_byte%0d", i), {40'b0, out_byte}, 48'h12);
      chk($sformatf("bp_hold_valid%0d", i), {47'b0, out_valid}, 48'd1);
      chk($sformatf("bp_in_ready%0d", i), {47'b0, in_ready}, 48'd0);
      tick();
    end
    out_ready = 1'b1;
    begin
      logic [23:0] rest;
      rest = 24'h345678;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk($sformatf("bp_seq_byte%0d", i + 1), {40'b0, out_byte}, {40'b0, rest[23-8*i -: 8]});
        chk($sformatf("bp_seq_valid%0d", i + 1), {47'b0, out_valid}, 48'd1);
      end
    end
    tick();
    chk("bp_drained", {47'b0, out_valid}, 48'd0);
    chk_bytes("bp", 4, 48'h12_34_56_78_0000);

    // Asynchronous reset with a byte pending and bits buffered.
    out_ready = 1'b0;
    send(32'h7, 6'd3, 1'b0);
    send(32'h3F, 6'd6, 1'b0);
    chk("pre_rst_valid", {47'b0, out_valid}, 48'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {47'b0, out_valid}, 48'd0);
    chk("async_rst_in_ready", {47'b0, in_ready}, 48'd1);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    got.delete();
    tick();
    send(32'hC3, 6'd8, 1'b1);
    wait_done("rst_seq_done");
    chk_bytes("rst_seq", 1, 48'hC3_0000_0000_00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
